// File: rtl/imem_load_controller_pkg.sv
//------------------------------------------------------------------------------
// Module : imem_load_controller_pkg
// Brief  : Shared controller state encoding and the END opcode used by cores
//          and the load controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_load_controller_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Opcode a core fetches to signal it has finished its program
    localparam int END_OPCODE = 38;

endpackage

`default_nettype wire

// File: rtl/imem_end_detect.sv
//------------------------------------------------------------------------------
// Module : imem_end_detect
// Brief  : Per-core END opcode compare with a sticky done flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_end_detect
    import imem_load_controller_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] END_OPCODE = DATA_W'(imem_load_controller_pkg::END_OPCODE)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              hit_o,
    output logic              done_o
);

    logic done_q;

    assign hit_o  = enable_i && (instr_i == END_OPCODE);
    assign done_o = done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else if (clear_i) begin
            done_q <= 1'b0;
        end else if (hit_o) begin
            done_q <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_load_controller.sv
//------------------------------------------------------------------------------
// Module : imem_load_controller
// Brief  : Loads a length-prefixed byte stream into the instruction memory,
//          releases the masked cores and reports completion on END fetch.
//          Optional macro CHECKSUM_EN adds a trailing XOR checksum byte.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_load_controller
    import imem_load_controller_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                NUM_CORES  = 4,
    parameter logic [DATA_W-1:0] END_OPCODE = DATA_W'(imem_load_controller_pkg::END_OPCODE)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start_load,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 write_en_file,
    output logic [ADDR_W-1:0]    addr_file,
    output logic [DATA_W-1:0]    instr_file,
    input  logic [DATA_W-1:0]    instruction0,
    input  logic [DATA_W-1:0]    instruction1,
    input  logic [DATA_W-1:0]    instruction2,
    input  logic [DATA_W-1:0]    instruction3,
    output logic [NUM_CORES-1:0] cores_run,
    output logic [NUM_CORES-1:0] core_done,
    output logic                 all_done,
    output logic                 load_error
);

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 we_q, we_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]    csum_q, csum_d;
`endif

    logic                 rx_fire_w;
    logic                 start_ok_w;
    logic                 last_w;
    logic                 run_w;
    logic [NUM_CORES-1:0] hit_w;
    logic [NUM_CORES-1:0] done_w;
    logic [DATA_W-1:0]    instr_w [4];

    assign instr_w[0] = instruction0;
    assign instr_w[1] = instruction1;
    assign instr_w[2] = instruction2;
    assign instr_w[3] = instruction3;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_LEN, S_LOAD: rx_ready = 1'b1;
`ifdef CHECKSUM_EN
            S_CSUM:        rx_ready = 1'b1;
`endif
            default:       rx_ready = 1'b0;
        endcase
    end

    assign rx_fire_w = rx_valid && rx_ready;
    assign run_w     = (state_q == S_RUN);
`ifdef CHECKSUM_EN
    assign start_ok_w = start_load &&
                        ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
`else
    assign start_ok_w = start_load && ((state_q == S_IDLE) || (state_q == S_DONE));
`endif
    // A stored length of 0 means 256 words: counter reaches 255 == 0 - 1
    assign last_w = (cnt_q == (len_q - ADDR_W'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        mask_d  = mask_q;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok_w) begin
                    state_d = S_LEN;
                    mask_d  = core_mask;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN: begin
                if (rx_fire_w) begin
                    len_d   = ADDR_W'(rx_data);
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rx_fire_w) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = rx_data;
                    cnt_d  = cnt_q + ADDR_W'(1);
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
                    if (last_w) state_d = S_CSUM;
`else
                    if (last_w) state_d = S_SETTLE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (rx_fire_w) begin
                    state_d = (rx_data == csum_q) ? S_SETTLE : S_ERR;
                end
            end
`endif
            S_SETTLE: begin
                // Hold until the final write has drained and one write-free cycle passed
                if (!we_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (((done_w | hit_w) & mask_q) == mask_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    generate
        for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
            imem_end_detect #(
                .DATA_W     (DATA_W),
                .END_OPCODE (END_OPCODE)
            ) u_end_detect (
                .clock    (clock),
                .reset_n  (reset_n),
                .clear_i  (start_ok_w),
                .enable_i (run_w && mask_q[i]),
                .instr_i  (instr_w[i]),
                .hit_o    (hit_w[i]),
                .done_o   (done_w[i])
            );
        end
    endgenerate

    assign write_en_file = we_q;
    assign addr_file     = addr_q;
    assign instr_file    = data_q;
    assign cores_run     = run_w ? (mask_q & ~done_w) : '0;
    assign core_done     = done_w;
    assign all_done      = (state_q == S_DONE);
`ifdef CHECKSUM_EN
    assign load_error    = (state_q == S_ERR);
`else
    assign load_error    = 1'b0;
`endif

endmodule

`default_nettype wire
